// File: rtl/board_shift_out.sv
// Serialises a snapshot of the game board MSB-first into an LED shift-register chain.
// Optional: BOARD_SHIFT_CHANGE_DETECT_EN suppresses frames whose board equals the last one sent.
module board_shift_out #(
    parameter int BOARD_W = 32,
    parameter int CLK_DIV = 2
) (
    input  logic               in_clka,
    input  logic               in_restart_n,
    input  logic [BOARD_W-1:0] in_board,
    input  logic               in_update,
    output logic               out_busy,
    output logic               out_sdata,
    output logic               out_sclk,
    output logic               out_latch,
    output logic               out_frame_done
);

    localparam int CNT_W = $clog2(BOARD_W);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    state_t             state_q, state_nx;
    logic [BOARD_W-1:0] shift_q, shift_nx;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_nx;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_nx;
    logic               pending_q, pending_nx;
    logic               div_end;
    logic               start_ok;
    logic               busy_nx, sdata_nx, sclk_nx, latch_nx, done_nx;

`ifdef BOARD_SHIFT_CHANGE_DETECT_EN
    logic [BOARD_W-1:0] shadow_q;
    logic               first_sent_q;
    logic               capture;

    assign start_ok = !first_sent_q || (in_board != shadow_q);
    assign capture  = start_ok &&
                      (((state_q == IDLE) && in_update) ||
                       ((state_q == DONE) && (pending_q || in_update)));

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            shadow_q     <= '0;
            first_sent_q <= 1'b0;
        end else if (capture) begin
            shadow_q     <= in_board;
            first_sent_q <= 1'b1;
        end
    end
`else
    assign start_ok = 1'b1;
`endif

    assign div_end = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        state_nx   = state_q;
        shift_nx   = shift_q;
        bit_cnt_nx = bit_cnt_q;
        div_cnt_nx = div_cnt_q;
        pending_nx = pending_q;

        case (state_q)
            IDLE: begin
                if (in_update && start_ok) begin
                    state_nx   = SHIFT_LO;
                    shift_nx   = in_board;
                    bit_cnt_nx = '0;
                    div_cnt_nx = '0;
                end
            end
            SHIFT_LO: begin
                pending_nx = pending_q | in_update;
                if (div_end) begin
                    div_cnt_nx = '0;
                    state_nx   = SHIFT_HI;
                end else begin
                    div_cnt_nx = div_cnt_q + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                pending_nx = pending_q | in_update;
                if (div_end) begin
                    div_cnt_nx = '0;
                    if (bit_cnt_q == CNT_W'(BOARD_W - 1)) begin
                        state_nx = LATCH;
                    end else begin
                        shift_nx   = {shift_q[BOARD_W-2:0], 1'b0};
                        bit_cnt_nx = bit_cnt_q + CNT_W'(1);
                        state_nx   = SHIFT_LO;
                    end
                end else begin
                    div_cnt_nx = div_cnt_q + DIV_W'(1);
                end
            end
            LATCH: begin
                pending_nx = pending_q | in_update;
                if (div_end) begin
                    div_cnt_nx = '0;
                    state_nx   = DONE;
                end else begin
                    div_cnt_nx = div_cnt_q + DIV_W'(1);
                end
            end
            DONE: begin
                // A request arriving in DONE itself merges into the pending one.
                pending_nx = 1'b0;
                if ((pending_q || in_update) && start_ok) begin
                    state_nx   = SHIFT_LO;
                    shift_nx   = in_board;
                    bit_cnt_nx = '0;
                    div_cnt_nx = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx  = (state_nx != IDLE);
        sclk_nx  = (state_nx == SHIFT_HI);
        latch_nx = (state_nx == LATCH);
        done_nx  = (state_nx == DONE);
        sdata_nx = ((state_nx == SHIFT_LO) || (state_nx == SHIFT_HI)) && shift_nx[BOARD_W-1];
    end

    // Outputs are registered from the next-state decode so they align with the state register.
    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            div_cnt_q      <= '0;
            pending_q      <= 1'b0;
            out_busy       <= 1'b0;
            out_sdata      <= 1'b0;
            out_sclk       <= 1'b0;
            out_latch      <= 1'b0;
            out_frame_done <= 1'b0;
        end else begin
            state_q        <= state_nx;
            shift_q        <= shift_nx;
            bit_cnt_q      <= bit_cnt_nx;
            div_cnt_q      <= div_cnt_nx;
            pending_q      <= pending_nx;
            out_busy       <= busy_nx;
            out_sdata      <= sdata_nx;
            out_sclk       <= sclk_nx;
            out_latch      <= latch_nx;
            out_frame_done <= done_nx;
        end
    end

endmodule
